// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, redirect input and decoder-side buffer head.
// master = fetch unit, slave = memory/execute/decode environment.
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvld;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_vld;
   logic        inst_rdy;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   modport master (
      output imem_req, imem_addr, inst_vld, inst, inst_pc,
      input  imem_gnt, imem_rvld, imem_rdata, redirect, redirect_pc, inst_rdy
   );

   modport slave (
      input  imem_req, imem_addr, inst_vld, inst, inst_pc,
      output imem_gnt, imem_rvld, imem_rdata, redirect, redirect_pc, inst_rdy
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues in-order memory requests, buffers returned words with their PCs,
// and discards stale responses after a control-flow redirect.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   inst_fetch_if.master bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

   state_e           state_q;
   logic [31:0]      fetch_pc_q;
   logic [CNT_W-1:0] outst_q;
   logic [CNT_W-1:0] stale_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [31:0]      data_mem [FIFO_DEPTH];
   logic [31:0]      pc_mem   [FIFO_DEPTH];

   logic             hs;
   logic             rvld_eff;
   logic             push;
   logic             pop;
   logic             room;
   logic [CNT_W-1:0] outst_d;
   logic [31:0]      resp_pc;

   // Outstanding requests are consecutive, so the oldest one's PC is recoverable from fetch_pc.
   always_comb begin
      room     = (32'(cnt_q) + 32'(outst_q)) < FIFO_DEPTH;
      hs       = bus.imem_req & bus.imem_gnt;
      rvld_eff = bus.imem_rvld & (outst_q != '0);
      push     = rvld_eff & (state_q == FETCH) & ~bus.redirect;
      pop      = (cnt_q != '0) & bus.inst_rdy;
      outst_d  = outst_q + CNT_W'(hs) - CNT_W'(rvld_eff);
      resp_pc  = fetch_pc_q - (32'(outst_q) << 2);
   end

   assign bus.imem_req  = (state_q == FETCH) & room & ~bus.redirect;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.inst_vld  = (cnt_q != '0);
   assign bus.inst      = (cnt_q != '0) ? data_mem[rd_ptr_q] : 32'h0;
   assign bus.inst_pc   = (cnt_q != '0) ? pc_mem[rd_ptr_q]   : 32'h0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         stale_q    <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         outst_q <= outst_d;
         if (bus.redirect) begin
            // Everything still in flight becomes stale; a response this cycle is already counted off.
            fetch_pc_q <= bus.redirect_pc & 32'hFFFF_FFFC;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            stale_q    <= outst_d;
            state_q    <= (outst_d != '0) ? DRAIN : FETCH;
         end else begin
            if (hs) fetch_pc_q <= fetch_pc_q + 32'd4;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case (state_q)
               IDLE:    state_q <= FETCH;
               FETCH:   state_q <= FETCH;
               DRAIN: begin
                  stale_q <= stale_q - CNT_W'(rvld_eff);
                  if (stale_q == CNT_W'(rvld_eff)) state_q <= FETCH;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= bus.imem_rdata;
         pc_mem[wr_ptr_q]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: queue-based reference of in-flight requests and buffered words,
// plus a directed wrap-around run on a second instance with a high reset PC.
module tb_inst_fetch;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] RPC_W = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_fetch_if bus ();
   inst_fetch_if bus_w ();

   inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   inst_fetch #(.RESET_PC(RPC_W), .FIFO_DEPTH(4)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bus_w.master)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Reference: requests in flight (oldest first) and buffered instructions (head first).
   typedef struct { logic [31:0] pc; bit stale; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

   req_t        outq[$];
   ent_t        fifo[$];
   logic [31:0] m_pc;
   bit          m_idle;

   function automatic bit has_stale();
      foreach (outq[i]) if (outq[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit chance(input int pct);
      return int'($urandom_range(0, 99)) < pct;
   endfunction

   task automatic model_reset();
      outq.delete();
      fifo.delete();
      m_pc   = RPC;
      m_idle = 1'b1;
   endtask

   task automatic step(input int p_gnt, input int p_rvld, input int p_rdy, input int p_redir);
      bit   exp_req;
      bit   pop;
      req_t r;
      ent_t e;
      @(negedge clk);
      bus.imem_gnt   = chance(p_gnt);
      bus.imem_rvld  = (outq.size() != 0) && chance(p_rvld);
      bus.imem_rdata = $urandom();
      bus.inst_rdy   = chance(p_rdy);
      bus.redirect   = !m_idle && chance(p_redir);
      case ($urandom_range(0, 3))
         0:       bus.redirect_pc = 32'h0000_1002;
         1:       bus.redirect_pc = 32'hFFFF_FFF6;
         default: bus.redirect_pc = $urandom();
      endcase
      #1;
      exp_req = !m_idle && !has_stale() && (fifo.size() + outq.size() < DEPTH) && !bus.redirect;
      check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) check_eq("imem_addr", bus.imem_addr, m_pc);
      check_eq("inst_vld", 32'(bus.inst_vld), 32'(fifo.size() != 0));
      if (fifo.size() != 0) begin
         check_eq("inst", bus.inst, fifo[0].data);
         check_eq("inst_pc", bus.inst_pc, fifo[0].pc);
      end else begin
         check_eq("inst_empty", bus.inst, 32'h0);
         check_eq("inst_pc_empty", bus.inst_pc, 32'h0);
      end
      @(posedge clk);
      pop = (fifo.size() != 0) && bus.inst_rdy;
      if (bus.redirect) begin
         if (bus.imem_rvld) r = outq.pop_front();
         fifo.delete();
         foreach (outq[i]) outq[i].stale = 1'b1;
         m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
         if (pop) void'(fifo.pop_front());
         if (bus.imem_rvld) begin
            r = outq.pop_front();
            if (!r.stale) begin
               e.data = bus.imem_rdata;
               e.pc   = r.pc;
               fifo.push_back(e);
            end
         end
         if (exp_req && bus.imem_gnt) begin
            r.pc    = m_pc;
            r.stale = 1'b0;
            outq.push_back(r);
            m_pc = m_pc + 32'd4;
         end
      end
      m_idle = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},  32'(bus.imem_req), 32'h0);
      check_eq({tag, "_vld"},  32'(bus.inst_vld), 32'h0);
      check_eq({tag, "_inst"}, bus.inst,          32'h0);
      check_eq({tag, "_pc"},   bus.inst_pc,       32'h0);
   endtask

   initial begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvld   = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_rdy    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      repeat (40)   step(100, 100, 100, 0);
      repeat (20)   step(100, 100, 0, 0);
      repeat (10)   step(100, 100, 30, 0);
      repeat (1500) step(70, 50, 60, 8);
      repeat (10)   step(100, 50, 0, 0);

      // Asynchronous reset with buffered and in-flight words.
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      bus.imem_rvld = 1'b0;
      bus.redirect  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      repeat (20)  step(100, 100, 100, 0);
      repeat (400) step(60, 60, 50, 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // High reset PC on a 4-deep instance: fetch addresses wrap through zero.
   initial begin
      logic [31:0] w_addr [4];
      w_addr[0] = 32'hFFFF_FFF8;
      w_addr[1] = 32'hFFFF_FFFC;
      w_addr[2] = 32'h0000_0000;
      w_addr[3] = 32'h0000_0004;
      bus_w.imem_gnt    = 1'b1;
      bus_w.imem_rvld   = 1'b0;
      bus_w.imem_rdata  = 32'h0;
      bus_w.redirect    = 1'b0;
      bus_w.redirect_pc = 32'h0;
      bus_w.inst_rdy    = 1'b0;
      @(negedge rst);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #2;
         check_eq("wrap_req", 32'(bus_w.imem_req), 32'((k >= 1) && (k <= 4)));
         if (k >= 1 && k <= 4) check_eq("wrap_addr", bus_w.imem_addr, w_addr[k-1]);
      end
      bus_w.imem_rvld  = 1'b1;
      bus_w.imem_rdata = 32'hA5A5_0001;
      @(negedge clk);
      bus_w.imem_rvld = 1'b0;
      #2;
      check_eq("wrap_vld",     32'(bus_w.inst_vld), 32'h1);
      check_eq("wrap_inst",    bus_w.inst,          32'hA5A5_0001);
      check_eq("wrap_inst_pc", bus_w.inst_pc,       32'hFFFF_FFF8);
      check_eq("wrap_full",    32'(bus_w.imem_req), 32'h0);
      bus_w.inst_rdy = 1'b1;
      @(negedge clk);
      bus_w.inst_rdy = 1'b0;
      #2;
      check_eq("wrap_pop_vld",  32'(bus_w.inst_vld), 32'h0);
      check_eq("wrap_pop_req",  32'(bus_w.imem_req), 32'h1);
      check_eq("wrap_pop_addr", bus_w.imem_addr,     32'h0000_0008);
   end

endmodule
